// File: rtl/bats_udp_feed_arbiter.sv
`default_nettype none
// ============================================================================
// bats_udp_feed_arbiter : packet-granular round-robin mux of two UDP word feeds
// onto one BATS parser input, with start-up/abort parser reset sequencing.
// Revision 1.0
// ============================================================================
module bats_udp_feed_arbiter #(
  parameter int RESET_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        Clk40,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [63:0] a_bytes,
  input  logic [7:0]  a_byte_enables,
  input  logic        a_last,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [63:0] b_bytes,
  input  logic [7:0]  b_byte_enables,
  input  logic        b_last,
  output logic        b_ready,
  input  logic        parser_ready,
  output logic [63:0] parser_bytes,
  output logic [7:0]  parser_byte_enables,
  output logic        parser_data_valid,
  output logic        parser_reset,
  output logic [31:0] pkt_count,
  output logic [15:0] abort_count,
  output logic        be_error,
  output logic        grant_b
);

  typedef enum logic [2:0] {
    S_INIT_RST = 3'd0,
    S_HOLDOFF  = 3'd1,
    S_IDLE     = 3'd2,
    S_STREAM   = 3'd3,
    S_GAP      = 3'd4,
    S_ABORT    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [7:0]  stall_q, stall_d;
  logic        grant_b_q, grant_b_d;
  logic        drain_q, drain_d;
  logic        dv_q, dv_d;
  logic [63:0] bytes_q, bytes_d;
  logic [7:0]  be_q, be_d;
  logic [31:0] pkt_q, pkt_d;
  logic [15:0] abort_q, abort_d;
  logic        be_err_q, be_err_d;

  logic        sel_valid, sel_last, stage_free, src_ready, accept, fwd, be_ok;
  logic [63:0] sel_bytes;
  logic [7:0]  sel_be, sel_be_n;

  always_comb begin
    sel_valid  = grant_b_q ? b_valid        : a_valid;
    sel_last   = grant_b_q ? b_last         : a_last;
    sel_bytes  = grant_b_q ? b_bytes        : a_bytes;
    sel_be     = grant_b_q ? b_byte_enables : a_byte_enables;
    sel_be_n   = ~sel_be;
    stage_free = !dv_q || parser_ready;
    // While draining an aborted packet the source is sunk regardless of state.
    src_ready  = ((state_q == S_STREAM) && stage_free) || drain_q;
    accept     = sel_valid && src_ready;
    fwd        = accept && (state_q == S_STREAM);
    // Last word: inverted enables must be a run of ones from bit 0.
    be_ok      = sel_last ? ((sel_be != 8'h00) && ((sel_be_n & (sel_be_n + 8'd1)) == 8'h00))
                          : (sel_be == 8'hFF);
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    stall_d   = stall_q;
    grant_b_d = grant_b_q;
    drain_d   = drain_q;
    dv_d      = dv_q;
    bytes_d   = bytes_q;
    be_d      = be_q;
    pkt_d     = pkt_q;
    abort_d   = abort_q;
    be_err_d  = be_err_q;

    if (fwd) begin
      dv_d    = 1'b1;
      bytes_d = sel_bytes;
      be_d    = sel_be;
      if (!be_ok) be_err_d = 1'b1;
    end else if (parser_ready) begin
      dv_d = 1'b0;
    end

    if (drain_q && accept && sel_last) drain_d = 1'b0;

    case (state_q)
      S_INIT_RST: begin
        dv_d = 1'b0;
        if (phase_q == 8'(RESET_CYCLES - 1)) begin
          phase_d = 8'd0;
          state_d = S_HOLDOFF;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_HOLDOFF: begin
        if (phase_q == 8'(HOLDOFF_CYCLES - 1)) begin
          phase_d = 8'd0;
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_IDLE: begin
        phase_d = 8'd0;
        stall_d = 8'd0;
        if (!drain_q && (a_valid || b_valid)) begin
          grant_b_d = (a_valid && b_valid) ? !grant_b_q : b_valid;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (fwd) begin
          stall_d = 8'd0;
          if (sel_last) begin
            pkt_d   = pkt_q + 32'd1;
            state_d = S_GAP;
          end
        end else if (!sel_valid && stage_free) begin
          // Only source-side silence counts; parser backpressure does not.
          if (stall_q == 8'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_ABORT;
            drain_d = 1'b1;
          end else begin
            stall_d = stall_q + 8'd1;
          end
        end
      end
      S_GAP: begin
        if (!dv_q) begin
          if (phase_q == 8'(GAP_CYCLES - 1)) begin
            phase_d = 8'd0;
            state_d = S_IDLE;
          end else begin
            phase_d = phase_q + 8'd1;
          end
        end
      end
      S_ABORT: begin
        dv_d    = 1'b0;
        phase_d = 8'd0;
        if (abort_q != 16'hFFFF) abort_d = abort_q + 16'd1;
        state_d = S_INIT_RST;
      end
      default: state_d = S_INIT_RST;
    endcase
  end

  always_ff @(posedge Clk40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT_RST;
      phase_q   <= 8'd0;
      stall_q   <= 8'd0;
      grant_b_q <= 1'b1;
      drain_q   <= 1'b0;
      dv_q      <= 1'b0;
      bytes_q   <= 64'd0;
      be_q      <= 8'd0;
      pkt_q     <= 32'd0;
      abort_q   <= 16'd0;
      be_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      stall_q   <= stall_d;
      grant_b_q <= grant_b_d;
      drain_q   <= drain_d;
      dv_q      <= dv_d;
      bytes_q   <= bytes_d;
      be_q      <= be_d;
      pkt_q     <= pkt_d;
      abort_q   <= abort_d;
      be_err_q  <= be_err_d;
    end
  end

  assign a_ready             = src_ready && !grant_b_q;
  assign b_ready             = src_ready && grant_b_q;
  assign parser_bytes        = bytes_q;
  assign parser_byte_enables = be_q;
  assign parser_data_valid   = dv_q;
  assign parser_reset        = (state_q == S_INIT_RST);
  assign pkt_count           = pkt_q;
  assign abort_count         = abort_q;
  assign be_error            = be_err_q;
  assign grant_b             = grant_b_q;

endmodule
`default_nettype wire

// File: doc/bats_udp_feed_arbiter.md
Name: bats_udp_feed_arbiter

Overview:
- Shares the BATS parser UDP input port between two packet sources: feed A and feed B, e.g. two multicast gap/replay units.
- Arbitrates round-robin at packet granularity and drives the parser's Bytes / Byte_Enables / data_valid / reset inputs.
- Owns the parser start-up reset sequence and enforces an idle gap between packets.
- Aborts a packet whose source stalls mid-packet and resets the parser after the abort.

Parameters:
RESET_CYCLES, 4, cycles parser_reset is held high after start-up or abort
HOLDOFF_CYCLES, 8, idle cycles after parser_reset deasserts before the first grant
GAP_CYCLES, 1, minimum cycles with data_valid=0 between consecutive packets
TIMEOUT_CYCLES, 255, consecutive cycles a granted source may hold src_valid=0 mid-packet before abort (8-bit counter)

Ports:
Clk40  in  1  single clock
reset_n  in  1  asynchronous active-low reset
a_valid  in  1  feed A word valid
a_bytes  in  64  feed A payload word; first byte is [63:56]
a_byte_enables  in  8  feed A byte enables; bit 7 = [63:56]
a_last  in  1  last word of feed A packet
a_ready  out  1  feed A word accepted this cycle when a_valid=1
b_valid, b_bytes, b_byte_enables, b_last, b_ready  same as A, for feed B
parser_ready  in  1  parser Ready_for_Udp_Input
parser_bytes  out  64  to parser Bytes
parser_byte_enables  out  8  to parser Byte_Enables
parser_data_valid  out  1  to parser data_valid
parser_reset  out  1  to parser reset control
pkt_count  out  32  packets fully forwarded, wraps at 2^32
abort_count  out  16  packets aborted, saturates at 0xFFFF
be_error  out  1  sticky; set on illegal byte-enable pattern
grant_b  out  1  0 = A owns, or last owned, the port; 1 = B

Behaviour:
- Reset values (reset_n=0, async):
  - state=INIT_RST; all parser_* outputs 0 except parser_reset=1.
  - a_ready=b_ready=0; counters 0; be_error=0; grant_b=1, so A wins first.
- States:
  - INIT_RST: parser_reset=1 for RESET_CYCLES, then HOLDOFF.
  - HOLDOFF: parser_reset=0, wait HOLDOFF_CYCLES, then IDLE.
  - IDLE: if exactly one source has valid=1, grant it. If both do, grant the one not currently in grant_b (round-robin). grant_b updates on grant. Go to STREAM next cycle; no word is accepted in the IDLE cycle.
  - STREAM: forward words from the granted source. On accepting a word with last=1, go to GAP and increment pkt_count.
  - GAP: data_valid=0 for GAP_CYCLES, then IDLE.
  - ABORT: entered from STREAM on timeout.
    - Go to INIT_RST; abort_count += 1; no pkt_count increment.
    - The granted source's remaining words are discarded: its ready=1 until a word with last=1 is accepted, while the parser is held in reset (INIT_RST/HOLDOFF). Discard continues across those states, and IDLE does not grant until it completes.
- Output stage: one register between source and parser.
  - src_ready = granted && STREAM && (!parser_data_valid || parser_ready).
  - On accept, load bytes/enables and set parser_data_valid=1.
  - A held word stays stable while parser_ready=0.
  - parser_data_valid clears the cycle after the final word is consumed with no new accept.
  - Latency: source accept to parser_data_valid is 1 cycle.
- The ungranted source's ready is always 0.
- Timeout:
  - In STREAM, a counter increments each cycle the granted src_valid=0 and clears on any accept.
  - Reaching TIMEOUT_CYCLES goes to ABORT.
  - parser_ready=0 stalls do not count.
- Byte enables:
  - Non-last words must be 0xFF.
  - The last word must be MSB-contiguous and non-zero (0x80, 0xC0, …, 0xFF).
  - Any other pattern sets be_error; the word is still forwarded unchanged.
- Simultaneous events:
  - last accepted on the same cycle the timeout would fire: the last wins and the packet counts as complete.
  - Source valid in GAP: ignored until IDLE.
- reset_n asserted mid-packet: everything returns to reset values immediately. Source drop handling after that is upstream's responsibility.

Test Plan:
- Start-up: release reset_n → parser_reset=1 for exactly 4 cycles, then 8 idle cycles. First a_ready is no earlier than cycle 13 after release, counting the IDLE grant cycle.
- Single packet A: words 0x0e00010102000000 (BE 0xFF) then 0x062020d206000000 (BE 0xFC, last) with parser_ready=1 → parser sees both words on consecutive cycles, 1 cycle after accept. data_valid=0 afterwards; pkt_count=1; be_error=0.
- Round-robin: A and B each hold 3 two-word packets → grant order A,B,A,B,A,B. Each packet is followed by ≥1 cycle of data_valid=0; pkt_count=6.
- Backpressure: parser_ready low for 5 cycles mid-packet → parser_bytes/enables stay stable; src ready=0; no timeout; no word lost or duplicated.
- Timeout: B stalls 255 cycles after its first word → abort_count=1, then parser_reset=1 for 4 cycles. B's remaining words up to last are drained with nothing on parser_data_valid. Next packet from A is then forwarded intact.
- BE error: non-last word with BE 0xF0 → be_error=1 and sticky until reset_n; the word still appears on parser_bytes.
